mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Params SHALL be: TIMEOUT_CYC, default 255, max slave wait cycles; ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  requester transaction request.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  `ADDR_W  byte address.
- m0_wdata / m1_wdata  in  `XLEN  write data.
- m0_rdata / m1_rdata  out  `XLEN  read data, valid when the matching ready is 1.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- mmio_req  out  1  request to the shared peripheral slave.
- mmio_we  out  1  to slave.
- mmio_addr  out  `ADDR_W  to slave.
- mmio_wdata  out  `XLEN  to slave.
- mmio_rdata  in  `XLEN  from slave.
- mmio_ready  in  1  slave completion.
- busy  out  1  1 while in BUSY.
- grant_id  out  1  requester owning the current or last transaction.
- timeout_err  out  1  sticky; set on any timeout.

Function
REQ-003 FSM SHALL have exactly two states, IDLE and BUSY.
REQ-004 In IDLE with at least one mN_req=1, the arbiter SHALL, on the next edge:
- latch the winner's we, addr and wdata into registers;
- set grant_id to the winner;
- clear the wait counter;
- enter BUSY.
REQ-005 Arbitration SHALL be round-robin: if both requesters are active, the one not granted last wins; after reset, m0 has priority.
REQ-006 In BUSY, mmio_req SHALL be 1 and mmio_we/addr/wdata SHALL come only from the latched registers; requester inputs have no effect while BUSY.
REQ-007 In IDLE, mmio_req SHALL be 0 and mmio_we/addr/wdata SHALL be 0.
REQ-008 In BUSY with mmio_ready=1, the granted port SHALL behave as follows in the same cycle (combinational pass-through):
- mN_ready=1;
- mN_rdata=mmio_rdata.
The FSM SHALL return to IDLE on the next edge.
REQ-009 The non-granted port SHALL always have ready=0 and rdata=0; the granted port SHALL have rdata=0 whenever its ready=0.
REQ-010 The wait counter SHALL increment on each BUSY cycle with mmio_ready=0.
REQ-011 On the cycle where the counter equals TIMEOUT_CYC-1 and mmio_ready=0, the arbiter SHALL:
- pulse the granted mN_ready with rdata=ERR_DATA;
- set timeout_err;
- return to IDLE.
REQ-012 If mmio_ready=1 on the timeout cycle, the slave response SHALL win and timeout_err SHALL NOT be set.
REQ-013 mmio_ready arriving while in IDLE SHALL be ignored.
REQ-014 Requesters SHALL hold req until their ready pulse.
REQ-015 A requester that drops req mid-transaction SHALL NOT abort the transaction; the transaction completes and its ready pulse is still issued.
REQ-016 After a completion, a still-asserted or new request SHALL be granted no earlier than one IDLE cycle later.
REQ-017 Minimum transaction latency SHALL be 2 cycles, from req sampled to ready.

Reset
REQ-018 With rst=1 at an edge, the arbiter SHALL:
- enter IDLE;
- clear all latched registers;
- set the wait counter to 0;
- set grant_id=0 and the last-grant pointer to favour m0 next;
- clear timeout_err.
All outputs SHALL then be 0.
REQ-019 Reset asserted mid-BUSY SHALL abandon the transaction with no ready pulse, and mmio_req SHALL be 0 in the cycle following the reset edge.

Structure
REQ-020 `ADDR_W and `XLEN SHALL come from defines.vh; TIMEOUT_CYC and ERR_DATA defaults SHALL be defined there as `MMIO_ARB_TIMEOUT and `MMIO_ARB_ERR_DATA.
REQ-021 The round-robin pick SHALL be a sub-module rr_arb2 with inputs req[1:0] and last, and output a one-hot gnt[1:0].
REQ-022 Target size SHALL be 120-250 lines of RTL.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single write: m0 writes 0x000000A5 to the LED address with the led_uart_mmio slave attached -> led_out=0x00A5; m0_ready pulses once; m1_ready stays 0.
- Simultaneous requests: m0 and m1 both request reads of the BTN address with btn_in=5'b10101 -> m0 is served first, then m1; both see rdata[4:0]=10101; grant_id sequence is 0 then 1.
- Fairness: both requesters hold req for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Timeout: stub slave with mmio_ready=0 and TIMEOUT_CYC=8 -> ready pulses exactly 8 cycles after BUSY entry, with rdata=0xDEADBEEF and timeout_err=1.
- Reset mid-BUSY: rst asserted 2 cycles into a read -> no ready pulse; mmio_req=0; the next m1 request is granted to m1 with m0 priority restored.
- Requester drops req after grant: the transaction completes, the slave sees exactly one transaction, and ready pulses.

Source files
------------

// File: rtl/mmio_arbiter_pkg.sv
// Shared widths, timeout defaults and FSM encoding for the two-requester MMIO arbiter.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MMIO_ARB_TIMEOUT
`define MMIO_ARB_TIMEOUT 255
`endif
`ifndef MMIO_ARB_ERR_DATA
`define MMIO_ARB_ERR_DATA 32'hDEAD_BEEF
`endif

package mmio_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // The wait counter never has to hold more than TIMEOUT_CYC-1.
  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
  endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_arb2
  import mmio_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO slave between two requesters with round-robin grant and a wait timeout.
// Handshake: a requester raises mN_req and holds it until mN_ready pulses for one cycle; the
// slave sees mmio_req high for the whole transaction and completes it with a one-cycle mmio_ready.
module mmio_arbiter
  import mmio_arbiter_pkg::*;
#(
  parameter int                TIMEOUT_CYC = `MMIO_ARB_TIMEOUT,
  parameter logic [`XLEN-1:0]  ERR_DATA    = `MMIO_ARB_ERR_DATA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [`ADDR_W-1:0] m0_addr,
  input  logic [`XLEN-1:0]   m0_wdata,
  output logic [`XLEN-1:0]   m0_rdata,
  output logic               m0_ready,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [`ADDR_W-1:0] m1_addr,
  input  logic [`XLEN-1:0]   m1_wdata,
  output logic [`XLEN-1:0]   m1_rdata,
  output logic               m1_ready,
  output logic               mmio_req,
  output logic               mmio_we,
  output logic [`ADDR_W-1:0] mmio_addr,
  output logic [`XLEN-1:0]   mmio_wdata,
  input  logic [`XLEN-1:0]   mmio_rdata,
  input  logic               mmio_ready,
  output logic               busy,
  output logic               grant_id,
  output logic               timeout_err
);

  localparam int                CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic               r_we;
  logic [`ADDR_W-1:0] r_addr;
  logic [`XLEN-1:0]   r_wdata;
  logic               r_grant;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_err;

  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_win;
  logic               w_busy;
  logic               w_timeout;
  logic               w_done;
  logic [`XLEN-1:0]   w_resp;

  assign w_req = {m1_req, m0_req};

  rr_arb2 u_rr (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_win     = w_gnt[1];
  assign w_busy    = (r_state == ST_BUSY);
  // A slave response on the last allowed cycle beats the timeout.
  assign w_timeout = w_busy && !mmio_ready && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && (mmio_ready || w_timeout);
  assign w_resp    = mmio_ready ? mmio_rdata : ERR_DATA;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (|w_req) w_next_state = ST_BUSY;
      ST_BUSY: if (w_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    mmio_req   = w_busy;
    mmio_we    = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    if (w_busy) begin
      mmio_we    = r_we;
      mmio_addr  = r_addr;
      mmio_wdata = r_wdata;
    end
    if (w_done) begin
      if (r_grant) begin
        m1_ready = 1'b1;
        m1_rdata = w_resp;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = w_resp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_grant       <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (!w_busy && (|w_req)) begin
        r_we    <= w_win ? m1_we    : m0_we;
        r_addr  <= w_win ? m1_addr  : m0_addr;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
        r_grant <= w_win;
        r_last  <= w_win;
        r_cnt   <= '0;
      end else if (w_busy && !mmio_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign grant_id    = r_grant;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: transaction-level model checked every cycle plus directed scenarios
// against a small LED/button slave model.
module tb_mmio_arbiter;

  localparam int          TMO      = 8;
  localparam logic [31:0] ERR      = 32'hDEAD_BEEF;
  localparam logic [31:0] LED_ADDR = 32'h0000_1000;
  localparam logic [31:0] BTN_ADDR = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mmio_req, mmio_we;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [31:0] mmio_rdata = 32'h0;
  logic        mmio_ready = 1'b0;
  logic        busy, grant_id, timeout_err;

  mmio_arbiter #(.TIMEOUT_CYC(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- slave model (LED register + button input) ----------------
  logic [15:0] led_out = 16'h0;
  logic [4:0]  btn_in  = 5'b0;
  int          s_txn   = 0;
  int          s_wait  = 0;
  int          s_lat   = 0;
  logic        s_stall = 1'b0;
  logic        s_spur  = 1'b0;

  always begin
    @(posedge clk);
    #1;
    mmio_ready = 1'b0;
    mmio_rdata = 32'h0;
    if (mmio_req === 1'b1) begin
      if (!s_stall) begin
        if (s_wait >= s_lat) begin
          mmio_ready = 1'b1;
          s_txn++;
          s_wait = 0;
          if (mmio_we) begin
            if (mmio_addr == LED_ADDR) led_out = mmio_wdata[15:0];
          end else if (mmio_addr == LED_ADDR) begin
            mmio_rdata = {16'h0, led_out};
          end else if (mmio_addr == BTN_ADDR) begin
            mmio_rdata = {27'h0, btn_in};
          end
        end else begin
          s_wait++;
        end
      end
    end else begin
      s_wait = 0;
      if (s_spur) begin
        mmio_ready = 1'b1;
        mmio_rdata = 32'h1234_5678;
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        cmp_en  = 1'b0;

  int          p_cnt[2];
  logic        p_drop[2];
  logic        p_we[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  logic        seen_rdy[2];

  // model state: one outstanding transaction at most
  logic        md_busy, md_gid, md_prev, md_terr, md_we;
  logic [31:0] md_addr, md_wdata;
  int          md_age;
  logic [31:0] exp_q[$];

  logic [31:0] log_id[$];
  logic [31:0] log_data[$];
  logic [31:0] log_gid[$];
  logic [31:0] log_len[$];
  int          run_len = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] log_at(input int sel, input int i);
    case (sel)
      0:       return (i < log_id.size())   ? log_id[i]   : 32'hFFFF_FFFF;
      1:       return (i < log_data.size()) ? log_data[i] : 32'hFFFF_FFFF;
      2:       return (i < log_gid.size())  ? log_gid[i]  : 32'hFFFF_FFFF;
      default: return (i < log_len.size())  ? log_len[i]  : 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] count_id(input logic [31:0] id);
    logic [31:0] c;
    c = 0;
    foreach (log_id[k]) if (log_id[k] == id) c++;
    return c;
  endfunction

  function automatic logic [31:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    log_id.delete();
    log_data.delete();
    log_gid.delete();
    log_len.delete();
    exp_q.delete();
  endtask

  // ---------------- compare + model step, once per cycle at the falling edge ----------------
  task automatic model_step();
    logic        done;
    logic        win;
    logic [31:0] resp;
    done = md_busy && ((mmio_ready === 1'b1) || (md_age == TMO - 1));
    resp = (mmio_ready === 1'b1) ? mmio_rdata : ERR;
    if (cmp_en) begin
      check1("busy", busy, md_busy);
      check1("grant_id", grant_id, md_gid);
      check1("timeout_err", timeout_err, md_terr);
      check1("mmio_req", mmio_req, md_busy);
      check1("mmio_we", mmio_we, md_busy & md_we);
      check32("mmio_addr", mmio_addr, md_busy ? md_addr : 32'h0);
      check32("mmio_wdata", mmio_wdata, md_busy ? md_wdata : 32'h0);
      check1("m0_ready", m0_ready, done && !md_gid);
      check1("m1_ready", m1_ready, done && md_gid);
      check32("m0_rdata", m0_rdata, (done && !md_gid) ? resp : 32'h0);
      check32("m1_rdata", m1_rdata, (done && md_gid) ? resp : 32'h0);
    end
    seen_rdy[0] = (m0_ready === 1'b1);
    seen_rdy[1] = (m1_ready === 1'b1);
    if (busy === 1'b1) run_len++;
    if (seen_rdy[0] || seen_rdy[1]) begin
      log_id.push_back(seen_rdy[1] ? 32'd1 : 32'd0);
      log_data.push_back(seen_rdy[1] ? m1_rdata : m0_rdata);
      log_gid.push_back(32'(grant_id));
      log_len.push_back(32'(run_len));
      run_len = 0;
    end
    if (rst) begin
      run_len  = 0;
      md_busy  = 1'b0;
      md_gid   = 1'b0;
      md_prev  = 1'b1;
      md_terr  = 1'b0;
      md_we    = 1'b0;
      md_addr  = 32'h0;
      md_wdata = 32'h0;
      md_age   = 0;
    end else if (!md_busy) begin
      if (m0_req || m1_req) begin
        win      = (m0_req && m1_req) ? !md_prev : m1_req;
        md_we    = win ? m1_we : m0_we;
        md_addr  = win ? m1_addr : m0_addr;
        md_wdata = win ? m1_wdata : m0_wdata;
        md_busy  = 1'b1;
        md_age   = 0;
        md_gid   = win;
        md_prev  = win;
        exp_q.push_back(32'(win));
      end
    end else if (done) begin
      md_busy = 1'b0;
      if (mmio_ready !== 1'b1) md_terr = 1'b1;
    end else begin
      md_age++;
    end
  endtask

  // One cycle: compare at the falling edge, then update requesters just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) if (seen_rdy[k] && p_cnt[k] > 0) p_cnt[k]--;
    m0_req   = (p_cnt[0] > 0) && !p_drop[0];
    m0_we    = p_we[0];
    m0_addr  = p_addr[0];
    m0_wdata = p_wdata[0];
    m1_req   = (p_cnt[1] > 0) && !p_drop[1];
    m1_we    = p_we[1];
    m1_addr  = p_addr[1];
    m1_wdata = p_wdata[1];
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((p_cnt[0] != 0 || p_cnt[1] != 0) && n < 300) begin
      tick();
      n++;
    end
    check32(name, 32'(p_cnt[0] + p_cnt[1]), 32'h0);
    repeat (3) tick();
  endtask

  task automatic set_port(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int cnt);
    p_we[k]    = we;
    p_addr[k]  = addr;
    p_wdata[k] = wdata;
    p_cnt[k]   = cnt;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int base;
    logic [31:0] fair_exp[6];
    fair_exp = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    for (int k = 0; k < 2; k++) begin
      p_cnt[k] = 0; p_drop[k] = 0; p_we[k] = 0; p_addr[k] = 0; p_wdata[k] = 0; seen_rdy[k] = 0;
    end
    md_busy = 0; md_gid = 0; md_prev = 1; md_terr = 0; md_we = 0;
    md_addr = 0; md_wdata = 0; md_age = 0;

    tick();
    tick();
    cmp_en = 1'b1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_mmio_req", mmio_req, 1'b0);
    check1("rst_grant_id", grant_id, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check1("rst_m0_ready", m0_ready, 1'b0);
    check32("rst_mmio_addr", mmio_addr, 32'h0);
    rst = 1'b0;
    tick();

    // simultaneous BTN reads: m0 first after reset, then m1
    clear_logs();
    btn_in = 5'b10101;
    s_lat  = 0;
    set_port(0, 1'b0, BTN_ADDR, 32'h0, 1);
    set_port(1, 1'b0, BTN_ADDR, 32'h0, 1);
    wait_done("sim_wait");
    check32("sim_first_id", log_at(0, 0), 32'd0);
    check32("sim_second_id", log_at(0, 1), 32'd1);
    check32("sim_data0", log_at(1, 0), 32'h0000_0015);
    check32("sim_data1", log_at(1, 1), 32'h0000_0015);
    check32("sim_gid0", log_at(2, 0), 32'd0);
    check32("sim_gid1", log_at(2, 1), 32'd1);

    // fairness: both hold req for three transactions each
    clear_logs();
    s_lat = 1;
    set_port(0, 1'b0, LED_ADDR, 32'h0, 3);
    set_port(1, 1'b0, LED_ADDR, 32'h0, 3);
    wait_done("fair_wait");
    check32("fair_count", 32'(log_gid.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check32($sformatf("fair_gid%0d", i), log_at(2, i), fair_exp[i]);
      check32($sformatf("fair_model%0d", i), exp_at(i), fair_exp[i]);
    end

    // slave ready while idle is ignored
    clear_logs();
    s_spur = 1'b1;
    tick();
    tick();
    s_spur = 1'b0;
    tick();
    check32("spur_no_pulse", 32'(log_id.size()), 32'd0);
    check1("spur_idle", busy, 1'b0);

    // single write of 0xA5 to the LED register by m0
    clear_logs();
    base = s_txn;
    s_lat = 1;
    set_port(0, 1'b1, LED_ADDR, 32'h0000_00A5, 1);
    wait_done("wr_wait");
    check32("wr_led", {16'h0, led_out}, 32'h0000_00A5);
    check32("wr_m0_pulses", count_id(32'd0), 32'd1);
    check32("wr_m1_pulses", count_id(32'd1), 32'd0);
    check32("wr_slave_txn", 32'(s_txn - base), 32'd1);

    // slave answers on the timeout cycle itself: response wins, no error
    clear_logs();
    s_lat = TMO - 1;
    set_port(0, 1'b0, BTN_ADDR, 32'h0, 1);
    wait_done("edge_wait");
    check32("edge_busy_len", log_at(3, 0), 32'd8);
    check32("edge_data", log_at(1, 0), 32'h0000_0015);
    check1("edge_no_err", timeout_err, 1'b0);

    // slave never answers: ERR_DATA after 8 BUSY cycles, sticky error
    clear_logs();
    s_stall = 1'b1;
    set_port(1, 1'b0, BTN_ADDR, 32'h0, 1);
    wait_done("tmo_wait");
    check32("tmo_id", log_at(0, 0), 32'd1);
    check32("tmo_busy_len", log_at(3, 0), 32'd8);
    check32("tmo_data", log_at(1, 0), ERR);
    check1("tmo_err", timeout_err, 1'b1);
    s_stall = 1'b0;

    // requester drops req once granted: transaction still completes once
    clear_logs();
    base = s_txn;
    s_lat = 3;
    set_port(0, 1'b1, LED_ADDR, 32'h0000_005A, 1);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check1("drop_granted", busy, 1'b1);
    p_drop[0] = 1'b1;
    wait_done("drop_wait");
    p_drop[0] = 1'b0;
    check32("drop_slave_txn", 32'(s_txn - base), 32'd1);
    check32("drop_pulses", 32'(log_id.size()), 32'd1);
    check32("drop_led", {16'h0, led_out}, 32'h0000_005A);

    // reset two cycles into a stalled m0 read
    clear_logs();
    s_stall = 1'b1;
    set_port(0, 1'b0, BTN_ADDR, 32'h0, 1);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check1("rmid_granted", busy, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    p_cnt[0] = 0;
    tick();
    check1("rmid_mmio_req", mmio_req, 1'b0);
    check1("rmid_busy", busy, 1'b0);
    check1("rmid_err_cleared", timeout_err, 1'b0);
    check32("rmid_no_pulse", 32'(log_id.size()), 32'd0);
    tick();
    rst = 1'b0;
    s_stall = 1'b0;
    s_lat = 0;
    tick();

    // m0 priority restored after reset, then m1 alone
    clear_logs();
    set_port(0, 1'b0, BTN_ADDR, 32'h0, 1);
    set_port(1, 1'b0, BTN_ADDR, 32'h0, 1);
    wait_done("post_wait");
    check32("post_first_id", log_at(0, 0), 32'd0);
    check32("post_second_id", log_at(0, 1), 32'd1);
    clear_logs();
    set_port(1, 1'b0, LED_ADDR, 32'h0, 1);
    wait_done("m1_wait");
    check32("m1_only_id", log_at(0, 0), 32'd1);
    check32("m1_only_gid", log_at(2, 0), 32'd1);
    check32("m1_only_data", log_at(1, 0), 32'h0000_005A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
